// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the multi-lane incrementing-pattern checker.
// Holds the state encoding, the seed-word builder and the per-lane restart test.
package seq_chk_pkg;

  localparam int unsigned SEQ_MAX_LANE_W = 64;
  localparam int unsigned SEQ_MAX_DW     = 1024;
  localparam int unsigned RUN_W          = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HUNT = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HUNT = HUNT,
    ST_LOCK = LOCK
  } state_t;

  // Word whose lane i holds (s + i) mod 2^lane_w; callers narrow it to their width.
  function automatic logic [SEQ_MAX_DW-1:0] seed_word(input int unsigned s,
                                                      input int unsigned lanes,
                                                      input int unsigned lane_w);
    logic [SEQ_MAX_DW-1:0]     w;
    logic [SEQ_MAX_LANE_W-1:0] mask;
    logic [SEQ_MAX_LANE_W-1:0] lane;
    w    = '0;
    mask = (lane_w >= SEQ_MAX_LANE_W) ? '1
         : ((SEQ_MAX_LANE_W'(1) << lane_w) - SEQ_MAX_LANE_W'(1));
    for (int unsigned i = 0; i < lanes; i++) begin
      lane = SEQ_MAX_LANE_W'(s + i) & mask;
      w    = w | (SEQ_MAX_DW'(lane) << (i * lane_w));
    end
    return w;
  endfunction

  // A sender restart puts lane idx at idx or idx+1; the lane arrives zero-extended.
  function automatic logic restart_lane(input logic [SEQ_MAX_LANE_W-1:0] lane,
                                        input int idx);
    return (lane == SEQ_MAX_LANE_W'(idx)) || (lane == SEQ_MAX_LANE_W'(idx + 1));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator with synchronous clear; clear beats a coincident add.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         t_clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] add,
  output logic [W-1:0] cnt
);

  logic [W:0] sum;

  assign sum = {1'b0, cnt} + {1'b0, add};

  always_ff @(posedge t_clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/seq_pattern_checker.sv
// Receive-side hunt/lock checker for the multi-lane incrementing counter pattern.
// Define SEQ_CHK_BIT_ERR_EN to build the bit-error popcount and bit_err_cnt.
module seq_pattern_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned LANE_W   = 32,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    t_clk,
  input  logic                    rst,
  input  logic                    check_start,
  input  logic                    check_en,
  input  logic [LANES*LANE_W-1:0] data,
  input  logic                    clr_cnt,
  output logic                    locked,
  output logic                    erro,
  output logic [LANES-1:0]        lane_err,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CNT_W-1:0]        beat_cnt,
  output logic [CNT_W-1:0]        bit_err_cnt,
  output logic [LANES*LANE_W-1:0] regc
);

  localparam int unsigned DW = LANES * LANE_W;
  localparam logic [DW-1:0] SEED1 = DW'(seed_word(1, LANES, LANE_W));

  state_t           state;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] bad_run;
  logic [RUN_W-1:0] good_run_inc;
  logic [RUN_W-1:0] bad_run_inc;

  logic [LANES-1:0] lane_mis;
  logic [LANES-1:0] lane_cons;
  logic [LANES-1:0] lane_rst;
  logic [DW-1:0]    data_inc;
  logic [DW-1:0]    regc_inc;

  logic match;
  logic consistent;
  logic restart;
  logic lock_beat;
  logic bad_beat;

  // Per-lane compares and increments; each lane wraps on its own, no carry between lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_mis[i]  = data[i*LANE_W +: LANE_W] != regc[i*LANE_W +: LANE_W];
    assign lane_cons[i] = data[i*LANE_W +: LANE_W] == LANE_W'(data[LANE_W-1:0] + LANE_W'(i));
    assign lane_rst[i]  = restart_lane(SEQ_MAX_LANE_W'(data[i*LANE_W +: LANE_W]), i);
    assign data_inc[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W] + LANE_W'(LANES);
    assign regc_inc[i*LANE_W +: LANE_W] = regc[i*LANE_W +: LANE_W] + LANE_W'(LANES);
  end

  assign match        = ~|lane_mis;
  assign consistent   = &lane_cons;
  assign restart      = &lane_rst;
  assign lock_beat    = check_start && check_en && (state == ST_LOCK);
  assign bad_beat     = lock_beat && !match && !restart;
  assign good_run_inc = good_run + RUN_W'(1);
  assign bad_run_inc  = bad_run + RUN_W'(1);

  // Hunt/lock state machine; the registered outputs move together with the state.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      locked   <= 1'b0;
      erro     <= 1'b0;
      lane_err <= '0;
      regc     <= SEED1;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      erro     <= 1'b0;
      lane_err <= '0;
      if (!check_start) begin
        state    <= ST_IDLE;
        locked   <= 1'b0;
        good_run <= '0;
        bad_run  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_HUNT;
          end
          ST_HUNT: begin
            if (check_en) begin
              if (consistent) begin
                regc <= data_inc;
                if (good_run_inc == RUN_W'(LOCK_CNT)) begin
                  state    <= ST_LOCK;
                  locked   <= 1'b1;
                  good_run <= '0;
                  bad_run  <= '0;
                end else begin
                  good_run <= good_run_inc;
                end
              end else begin
                good_run <= '0;
              end
            end
          end
          ST_LOCK: begin
            if (check_en) begin
              if (match) begin
                regc    <= regc_inc;
                bad_run <= '0;
              end else if (restart) begin
                regc    <= data_inc;
                bad_run <= '0;
              end else begin
                erro     <= 1'b1;
                lane_err <= lane_mis;
                regc     <= data_inc;
                if (bad_run_inc == RUN_W'(LOSS_CNT)) begin
                  state    <= ST_HUNT;
                  locked   <= 1'b0;
                  good_run <= '0;
                  bad_run  <= '0;
                end else begin
                  bad_run <= bad_run_inc;
                end
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .t_clk (t_clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (bad_beat),
    .add   (CNT_W'(1)),
    .cnt   (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_beat_cnt (
    .t_clk (t_clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (lock_beat),
    .add   (CNT_W'(1)),
    .cnt   (beat_cnt)
  );

`ifdef SEQ_CHK_BIT_ERR_EN
  localparam int unsigned POP_W = $clog2(DW + 1);

  logic [POP_W-1:0] pop_q;
  logic             pop_v;
  logic [CNT_W-1:0] pop_add;

  function automatic logic [POP_W-1:0] popcount(input logic [DW-1:0] v);
    logic [POP_W-1:0] sum;
    sum = '0;
    for (int k = 0; k < DW; k++) begin
      sum = sum + POP_W'(v[k]);
    end
    return sum;
  endfunction

  // Popcount is registered, so bit_err_cnt trails erro by one cycle.
  always_ff @(posedge t_clk) begin
    if (rst) begin
      pop_v <= 1'b0;
      pop_q <= '0;
    end else begin
      pop_v <= bad_beat;
      pop_q <= bad_beat ? popcount(data ^ regc) : '0;
    end
  end

  // A narrow counter must see an oversized popcount as a saturating add.
  if (POP_W > CNT_W) begin : g_pop_clip
    assign pop_add = (|pop_q[POP_W-1:CNT_W]) ? '1 : pop_q[CNT_W-1:0];
  end else begin : g_pop_ext
    assign pop_add = CNT_W'(pop_q);
  end

  sat_counter #(.W(CNT_W)) u_bit_err_cnt (
    .t_clk (t_clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (pop_v),
    .add   (pop_add),
    .cnt   (bit_err_cnt)
  );
`else
  assign bit_err_cnt = '0;
`endif

endmodule
